// File: rtl/fsm_out_monitor.sv
// Change-capture monitor for an FSM output: timestamped change events are queued in a FWFT FIFO.
// Optional drop counter output enabled by defining FSM_MON_DROP_CNT_EN.
module fsm_out_monitor #(
  parameter int unsigned OUT_WIDTH = 4,
  parameter int unsigned TS_WIDTH  = 16,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned CNT_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [OUT_WIDTH-1:0] out_signal,
  input  logic                 sample_en,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [OUT_WIDTH-1:0] evt_value,
  output logic [TS_WIDTH-1:0]  evt_time,
  output logic [CNT_WIDTH-1:0] fill_level,
  output logic                 overflow,
  input  logic                 clr_ovf
`ifdef FSM_MON_DROP_CNT_EN
  ,
  output logic [7:0]           drop_cnt
`endif
);

  localparam int unsigned ENTRY_W = TS_WIDTH + OUT_WIDTH;
  localparam int unsigned PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(DEPTH);

  logic [TS_WIDTH-1:0]  r_ts;
  logic [OUT_WIDTH-1:0] r_prev;
  logic                 r_prev_valid;
  logic [ENTRY_W-1:0]   r_mem [DEPTH];
  logic [PTR_W-1:0]     r_wptr;
  logic [PTR_W-1:0]     r_rptr;
  logic [CNT_WIDTH-1:0] r_count;
  logic                 r_overflow;
  logic [ENTRY_W-1:0]   r_hold;

  logic                 w_empty;
  logic                 w_full;
  logic                 w_event;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_drop;
  logic [ENTRY_W-1:0]   w_head;
  logic [ENTRY_W-1:0]   w_out_entry;
  logic [CNT_WIDTH-1:0] w_count_next;
  logic                 w_overflow_next;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_CNT);
  assign w_event = sample_en && (!r_prev_valid || (out_signal != r_prev));
  assign w_pop   = !w_empty && evt_ready;
  // A full FIFO still accepts an event when the head leaves in the same cycle.
  assign w_push  = w_event && (!w_full || w_pop);
  assign w_drop  = w_event && w_full && !w_pop;
  assign w_head  = r_mem[r_rptr];

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + CNT_WIDTH'(1);
      2'b01:   w_count_next = r_count - CNT_WIDTH'(1);
      default: w_count_next = r_count;
    endcase
  end

  always_comb begin
    w_overflow_next = r_overflow;
    if (w_drop) begin
      w_overflow_next = 1'b1;
    end else if (clr_ovf) begin
      w_overflow_next = 1'b0;
    end
  end

  // When empty, present the most recently popped head (zero after reset).
  assign w_out_entry = w_empty ? r_hold : w_head;
  assign evt_valid   = !w_empty;
  assign evt_value   = w_out_entry[OUT_WIDTH-1:0];
  assign evt_time    = w_out_entry[ENTRY_W-1:OUT_WIDTH];
  assign fill_level  = r_count;
  assign overflow    = r_overflow;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ts         <= '0;
      r_prev       <= '0;
      r_prev_valid <= 1'b0;
    end else begin
      r_ts <= r_ts + TS_WIDTH'(1);
      if (sample_en) begin
        r_prev       <= out_signal;
        r_prev_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
      r_wptr <= '0;
      r_rptr <= '0;
      r_hold <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= {r_ts, out_signal};
        r_wptr        <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
        r_hold <= w_head;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_count    <= w_count_next;
      r_overflow <= w_overflow_next;
    end
  end

`ifdef FSM_MON_DROP_CNT_EN
  logic [7:0] r_drop_cnt;
  logic [7:0] w_drop_cnt_next;

  // A drop coinciding with a clear restarts the count at one.
  always_comb begin
    w_drop_cnt_next = r_drop_cnt;
    if (w_drop) begin
      if (clr_ovf) begin
        w_drop_cnt_next = 8'd1;
      end else if (r_drop_cnt != 8'hFF) begin
        w_drop_cnt_next = r_drop_cnt + 8'd1;
      end
    end else if (clr_ovf) begin
      w_drop_cnt_next = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop_cnt <= 8'd0;
    end else begin
      r_drop_cnt <= w_drop_cnt_next;
    end
  end

  assign drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_fsm_out_monitor.sv
// Directed bench for fsm_out_monitor: default-size instance plus a TS_WIDTH=4 instance for wrap.
module tb_fsm_out_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, sample_en, evt_ready, clr_ovf, evt_valid, overflow;
  logic [3:0]  out_signal, evt_value, fill_level;
  logic [15:0] evt_time;
  logic [7:0]  drop_cnt;

  logic        t_rst, t_en, t_ready, t_clr, t_valid, t_ovf;
  logic [3:0]  t_out, t_value, t_fill, t_time;
  logic [7:0]  t_drop;

  int n_checks = 0;
  int n_errors = 0;

  fsm_out_monitor #(
    .OUT_WIDTH(4), .TS_WIDTH(16), .DEPTH(8), .CNT_WIDTH(4)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .out_signal (out_signal),
    .sample_en  (sample_en),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_value  (evt_value),
    .evt_time   (evt_time),
    .fill_level (fill_level),
    .overflow   (overflow),
    .clr_ovf    (clr_ovf)
`ifdef FSM_MON_DROP_CNT_EN
    ,
    .drop_cnt   (drop_cnt)
`endif
  );

  fsm_out_monitor #(
    .OUT_WIDTH(4), .TS_WIDTH(4), .DEPTH(8), .CNT_WIDTH(4)
  ) u_dut_ts4 (
    .clk        (clk),
    .rst        (t_rst),
    .out_signal (t_out),
    .sample_en  (t_en),
    .evt_valid  (t_valid),
    .evt_ready  (t_ready),
    .evt_value  (t_value),
    .evt_time   (t_time),
    .fill_level (t_fill),
    .overflow   (t_ovf),
    .clr_ovf    (t_clr)
`ifdef FSM_MON_DROP_CNT_EN
    ,
    .drop_cnt   (t_drop)
`endif
  );

`ifndef FSM_MON_DROP_CNT_EN
  assign drop_cnt = 8'd0;
  assign t_drop   = 8'd0;
`endif

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance into the next cycle; inputs are then driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    sample_en  = 1'b0;
    evt_ready  = 1'b0;
    clr_ovf    = 1'b0;
    out_signal = 4'd0;
    step();
    rst = 1'b0;
    check_eq("rst_valid", 32'(evt_valid), 32'd0);
    check_eq("rst_fill", 32'(fill_level), 32'd0);
    check_eq("rst_ovf", 32'(overflow), 32'd0);
    check_eq("rst_value", 32'(evt_value), 32'd0);
    check_eq("rst_time", 32'(evt_time), 32'd0);
`ifdef FSM_MON_DROP_CNT_EN
    check_eq("rst_drop_cnt", 32'(drop_cnt), 32'd0);
`endif
  endtask

  logic [3:0]  t2_vals [6];
  logic [3:0]  rec_val [8];
  logic [15:0] rec_time [8];
  int          n_rec;
  logic [3:0]  exp_v [8];
  logic [15:0] exp_t [8];

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1);
  end

  initial begin
    t_rst = 1'b1; t_en = 1'b0; t_ready = 1'b0; t_clr = 1'b0; t_out = 4'd0;

    // Constant zero input yields exactly one event (0, t=0).
    do_reset();
    sample_en  = 1'b1;
    out_signal = 4'd0;
    step();
    check_eq("t1_valid", 32'(evt_valid), 32'd1);
    check_eq("t1_value", 32'(evt_value), 32'd0);
    check_eq("t1_time", 32'(evt_time), 32'd0);
    check_eq("t1_fill", 32'(fill_level), 32'd1);
    repeat (4) step();
    check_eq("t1_fill_held", 32'(fill_level), 32'd1);
    check_eq("t1_valid_held", 32'(evt_valid), 32'd1);

    // Change stream drained continuously.
    do_reset();
    t2_vals   = '{4'd3, 4'd3, 4'd5, 4'd5, 4'd5, 4'd9};
    evt_ready = 1'b1;
    sample_en = 1'b1;
    n_rec     = 0;
    for (int i = 0; i < 9; i++) begin
      if (i < 6) begin
        out_signal = t2_vals[i];
      end else begin
        sample_en = 1'b0;
      end
      if (evt_valid) begin
        if (n_rec < 8) begin
          rec_val[n_rec]  = evt_value;
          rec_time[n_rec] = evt_time;
        end
        n_rec++;
      end
      step();
    end
    check_eq("t2_count", 32'(n_rec), 32'd3);
    check_eq("t2_v0", 32'(rec_val[0]), 32'd3);
    check_eq("t2_t0", 32'(rec_time[0]), 32'd0);
    check_eq("t2_v1", 32'(rec_val[1]), 32'd5);
    check_eq("t2_t1", 32'(rec_time[1]), 32'd2);
    check_eq("t2_v2", 32'(rec_val[2]), 32'd9);
    check_eq("t2_t2", 32'(rec_time[2]), 32'd5);
    check_eq("t2_ovf", 32'(overflow), 32'd0);
    check_eq("t2_fill", 32'(fill_level), 32'd0);

    // Fill past capacity: 8 kept, 2 dropped.
    do_reset();
    sample_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      out_signal = 4'(i + 1);
      step();
    end
    check_eq("t3_fill", 32'(fill_level), 32'd8);
    check_eq("t3_ovf", 32'(overflow), 32'd1);
    check_eq("t3_head_v", 32'(evt_value), 32'd1);
    check_eq("t3_head_t", 32'(evt_time), 32'd0);
`ifdef FSM_MON_DROP_CNT_EN
    check_eq("t3_drop_cnt", 32'(drop_cnt), 32'd2);
`endif

    // Full + pop + event + clear: accepted, overflow cleared.
    out_signal = 4'd11;
    evt_ready  = 1'b1;
    clr_ovf    = 1'b1;
    step();
    check_eq("t4_fill", 32'(fill_level), 32'd8);
    check_eq("t4_ovf", 32'(overflow), 32'd0);
    check_eq("t4_head_v", 32'(evt_value), 32'd2);
    check_eq("t4_head_t", 32'(evt_time), 32'd1);
`ifdef FSM_MON_DROP_CNT_EN
    check_eq("t4_drop_cnt", 32'(drop_cnt), 32'd0);
`endif

    // Full + drop + clear: set wins.
    out_signal = 4'd12;
    evt_ready  = 1'b0;
    clr_ovf    = 1'b1;
    step();
    clr_ovf = 1'b0;
    check_eq("t5_ovf", 32'(overflow), 32'd1);
    check_eq("t5_fill", 32'(fill_level), 32'd8);
`ifdef FSM_MON_DROP_CNT_EN
    check_eq("t5_drop_cnt", 32'(drop_cnt), 32'd1);
`endif

    // Drain and verify retained order.
    exp_v = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd11};
    exp_t = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd10};
    sample_en = 1'b0;
    evt_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check_eq($sformatf("drain_valid%0d", k), 32'(evt_valid), 32'd1);
      check_eq($sformatf("drain_v%0d", k), 32'(evt_value), 32'(exp_v[k]));
      check_eq($sformatf("drain_t%0d", k), 32'(evt_time), 32'(exp_t[k]));
      step();
    end
    check_eq("drain_empty_valid", 32'(evt_valid), 32'd0);
    check_eq("drain_empty_fill", 32'(fill_level), 32'd0);
    check_eq("drain_hold_v", 32'(evt_value), 32'd11);
    check_eq("drain_hold_t", 32'(evt_time), 32'd10);
    check_eq("drain_ovf_sticky", 32'(overflow), 32'd1);
    evt_ready = 1'b0;

    // TS_WIDTH=4: wrap, then reset with events queued.
    t_rst = 1'b0;
    for (int c = 0; c < 14; c++) step();
    t_en  = 1'b1;
    t_out = 4'd2;
    step();
    step();
    step();
    t_out = 4'd3;
    step();
    t_out = 4'd4;
    step();
    check_eq("ts_fill3", 32'(t_fill), 32'd3);
    check_eq("ts_head_v14", 32'(t_value), 32'd2);
    check_eq("ts_head_t14", 32'(t_time), 32'd14);
    t_out   = 4'd5;
    t_ready = 1'b1;
    step();
    check_eq("ts_fill_still3", 32'(t_fill), 32'd3);
    check_eq("ts_head_v_wrap", 32'(t_value), 32'd3);
    check_eq("ts_head_t_wrap", 32'(t_time), 32'd1);
    t_rst   = 1'b1;
    t_en    = 1'b0;
    t_ready = 1'b0;
    step();
    check_eq("ts_rst_valid", 32'(t_valid), 32'd0);
    check_eq("ts_rst_fill", 32'(t_fill), 32'd0);
    t_rst = 1'b0;
    t_en  = 1'b1;
    t_out = 4'd5;
    step();
    check_eq("ts_post_valid", 32'(t_valid), 32'd1);
    check_eq("ts_post_v", 32'(t_value), 32'd5);
    check_eq("ts_post_t", 32'(t_time), 32'd0);
    check_eq("ts_post_fill", 32'(t_fill), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
